// File: rtl/ps2_scancode_decoder.sv
// ps2_scancode_decoder: folds Set-2 E0/F0 prefixes into key events queued in a show-ahead FIFO
module ps2_scancode_decoder #(
  parameter int TIMEOUT_CYCLES = 25000,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk25,
  input  logic       reset,
  input  logic [7:0] byte_in,
  input  logic       byte_valid,
  output logic [7:0] evt_code,
  output logic       evt_ext,
  output logic       evt_brk,
  output logic       evt_valid,
  input  logic       evt_rd,
  output logic       overflow,
  input  logic       clr_overflow,
  output logic       busy
);
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] FULL = CW'(FIFO_DEPTH);
  typedef enum logic [1:0] {IDLE, EXT, BRK, EXT_BRK} state_t;
  state_t state, nxt;
  logic [TW-1:0] tcnt;
  logic [9:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wp, rp;
  logic [CW-1:0] count;
  logic ext, brk, is_e0, is_f0, is_err, emit, full, rd, wr, expire;
  always_comb begin
    ext = state == EXT || state == EXT_BRK;
    brk = state == BRK || state == EXT_BRK;
    is_e0 = byte_in == 8'hE0;
    is_f0 = byte_in == 8'hF0;
    is_err = byte_in == 8'h00 || byte_in == 8'hFF;
    emit = byte_valid && !is_e0 && !is_f0 && !is_err;
    nxt = is_err ? IDLE : is_e0 ? (brk ? EXT_BRK : EXT) : is_f0 ? (ext ? EXT_BRK : BRK) : IDLE;
    expire = state != IDLE && tcnt == TLAST;
    evt_valid = count != '0;
    full = count == FULL;
    rd = evt_rd && evt_valid;
    wr = emit && (!full || rd);
    evt_code = evt_valid ? mem[rp][7:0] : '0;
    evt_brk = evt_valid ? mem[rp][8] : 1'b0;
    evt_ext = evt_valid ? mem[rp][9] : 1'b0;
    busy = state != IDLE;
  end
  always_ff @(posedge clk25) begin
    if (reset) begin
      state <= IDLE;
      tcnt <= '0;
      wp <= '0;
      rp <= '0;
      count <= '0;
      overflow <= 1'b0;
    end else begin
      state <= byte_valid ? nxt : expire ? IDLE : state;
      tcnt <= (byte_valid || state == IDLE || expire) ? '0 : tcnt + TW'(1);
      if (wr) begin
        mem[wp] <= {ext, brk, byte_in};
        wp <= wp + AW'(1);
      end
      if (rd) rp <= rp + AW'(1);
      count <= count + CW'(wr) - CW'(rd);
      overflow <= (emit && full && !rd) || (overflow && !clr_overflow);
    end
  end
endmodule

// File: tb/tb_ps2_scancode_decoder.sv
// tb_ps2_scancode_decoder: directed stimulus with a queued scoreboard checked by an independent monitor
module tb_ps2_scancode_decoder;
  logic clk25 = 1'b0;
  logic reset = 1'b1;
  logic [7:0] byte_in = '0;
  logic byte_valid = 1'b0;
  logic evt_rd = 1'b0;
  logic clr_overflow = 1'b0;
  logic [7:0] evt_code;
  logic evt_ext, evt_brk, evt_valid, overflow, busy;
  int checks = 0;
  int errors = 0;
  logic [9:0] exp_q [$];
  ps2_scancode_decoder #(.TIMEOUT_CYCLES(16), .FIFO_DEPTH(4)) dut (
    .clk25(clk25), .reset(reset), .byte_in(byte_in), .byte_valid(byte_valid),
    .evt_code(evt_code), .evt_ext(evt_ext), .evt_brk(evt_brk), .evt_valid(evt_valid),
    .evt_rd(evt_rd), .overflow(overflow), .clr_overflow(clr_overflow), .busy(busy)
  );
  always #20 clk25 = ~clk25;
  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  always @(negedge clk25) begin
    if (!reset && evt_valid && evt_rd) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL pop_unexpected: got %h expected none", {evt_ext, evt_brk, evt_code});
      end else begin
        chk("event", {6'd0, evt_ext, evt_brk, evt_code}, {6'd0, exp_q.pop_front()});
      end
    end
  end
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk25);
      #1;
    end
  endtask
  task automatic send(input logic [7:0] b);
    byte_in = b;
    byte_valid = 1'b1;
    tick(1);
    byte_valid = 1'b0;
  endtask
  task automatic pop_one();
    evt_rd = 1'b1;
    tick(1);
    evt_rd = 1'b0;
  endtask
  task automatic push(input logic ext, input logic brk, input logic [7:0] code);
    exp_q.push_back({ext, brk, code});
  endtask
  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
  initial begin
    tick(3);
    reset = 1'b0;
    chk("rst_valid", 16'(evt_valid), 16'd0);
    chk("rst_busy", 16'(busy), 16'd0);
    chk("rst_overflow", 16'(overflow), 16'd0);
    chk("rst_code", 16'({evt_ext, evt_brk, evt_code}), 16'd0);
    push(0, 0, 8'h1C);
    send(8'h1C);
    chk("make_latency", 16'(evt_valid), 16'd1);
    pop_one();
    chk("after_pop_valid", 16'(evt_valid), 16'd0);
    send(8'hE0);
    tick(9);
    chk("busy_after_e0", 16'(busy), 16'd1);
    send(8'hF0);
    tick(9);
    chk("busy_after_f0", 16'(busy), 16'd1);
    chk("no_prefix_event", 16'(evt_valid), 16'd0);
    push(1, 1, 8'h75);
    send(8'h75);
    chk("busy_after_75", 16'(busy), 16'd0);
    pop_one();
    chk("single_event", 16'(evt_valid), 16'd0);
    send(8'hF0);
    tick(15);
    chk("busy_before_expiry", 16'(busy), 16'd1);
    tick(1);
    chk("busy_at_expiry", 16'(busy), 16'd0);
    chk("no_timeout_event", 16'(evt_valid), 16'd0);
    push(0, 0, 8'h1C);
    send(8'h1C);
    pop_one();
    push(1, 0, 8'h75);
    send(8'hE0);
    send(8'h75);
    push(0, 0, 8'hE1);
    send(8'hE1);
    pop_one();
    pop_one();
    push(0, 0, 8'h15);
    push(0, 0, 8'h1D);
    push(0, 0, 8'h24);
    push(0, 0, 8'h2D);
    send(8'h15);
    send(8'h1D);
    send(8'h24);
    chk("not_yet_overflow", 16'(overflow), 16'd0);
    send(8'h2D);
    send(8'h2C);
    chk("overflow_set", 16'(overflow), 16'd1);
    clr_overflow = 1'b1;
    tick(1);
    clr_overflow = 1'b0;
    chk("overflow_clr", 16'(overflow), 16'd0);
    for (int i = 0; i < 4; i++) pop_one();
    chk("drained", 16'(evt_valid), 16'd0);
    push(0, 0, 8'h15);
    push(0, 0, 8'h1D);
    push(0, 0, 8'h24);
    push(0, 0, 8'h2D);
    send(8'h15);
    send(8'h1D);
    send(8'h24);
    send(8'h2D);
    push(0, 0, 8'h3C);
    byte_in = 8'h3C;
    byte_valid = 1'b1;
    evt_rd = 1'b1;
    tick(1);
    byte_valid = 1'b0;
    evt_rd = 1'b0;
    chk("full_rw_overflow", 16'(overflow), 16'd0);
    for (int i = 0; i < 4; i++) pop_one();
    chk("full_rw_drained", 16'(evt_valid), 16'd0);
    send(8'hE0);
    send(8'hFF);
    chk("ff_idle", 16'(busy), 16'd0);
    chk("ff_no_event", 16'(evt_valid), 16'd0);
    send(8'hE0);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    chk("reset_mid_busy", 16'(busy), 16'd0);
    push(0, 0, 8'h74);
    send(8'h74);
    pop_one();
    tick(2);
    chk("scoreboard_empty", 16'(exp_q.size()), 16'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
